// File: rtl/key_conditioner.sv
// Button/switch front-end for the clock/alarm block: two-flop sync, per-channel debounce,
// single-cycle press pulses, and auto-repeat on the pill key.
module key_conditioner #(
    parameter int unsigned DEB_CYCLES   = 20,
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start_n,
    input  logic       key_stop_n,
    input  logic       key_pill_n,
    input  logic       sw_bottle,
    input  logic       rep_en,
    output logic       start,
    output logic       stop,
    output logic       pill_pulse,
    output logic       bottle_ok,
    output logic [2:0] key_held
);

    localparam int          NumCh  = 4;
    localparam int unsigned DebW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;

    localparam logic [DebW-1:0] DebLast   = DebW'(DEB_CYCLES - 1);
    localparam logic [RepW-1:0] DelayLast = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] RateLast  = RepW'(REPEAT_RATE - 1);

    // Channel index: 0 start, 1 stop, 2 pill, 3 bottle
    localparam int ChStart  = 0;
    localparam int ChStop   = 1;
    localparam int ChPill   = 2;
    localparam int ChBottle = 3;

    typedef enum logic [1:0] {
        RIdle   = 2'd0,
        RDelay  = 2'd1,
        RRepeat = 2'd2
    } rep_state_e;

    logic [NumCh-1:0] raw;
    logic [NumCh-1:0] s1_q;
    logic [NumCh-1:0] s2_q;
    logic [NumCh-1:0] stable_q;
    logic [NumCh-1:0] stable_d;
    logic [DebW-1:0]  deb_cnt_q [NumCh];
    logic [DebW-1:0]  deb_cnt_d [NumCh];

    logic [2:0] rise;
    logic       start_q;
    logic       start_d;
    logic       stop_q;
    logic       stop_d;
    logic       pill_q;
    logic       pill_d;
    logic       rep_fire;

    rep_state_e      rep_state_q;
    rep_state_e      rep_state_d;
    logic [RepW-1:0] rep_cnt_q;
    logic [RepW-1:0] rep_cnt_d;

    // All channels become active-high "pressed/present" before synchronisation.
    assign raw = {sw_bottle, ~key_pill_n, ~key_stop_n, ~key_start_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NumCh; i++) begin
            deb_cnt_d[i] = '0;
            if (s2_q[i] == stable_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DebLast) begin
                stable_d[i]  = s2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < NumCh; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < NumCh; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // Stop wins a same-cycle collision; start's stable state still advances so it never fires late.
    always_comb begin
        rise    = stable_d[2:0] & ~stable_q[2:0];
        stop_d  = rise[ChStop];
        start_d = rise[ChStart] & ~rise[ChStop];
    end

    always_comb begin
        rep_state_d = rep_state_q;
        rep_cnt_d   = rep_cnt_q;
        rep_fire    = 1'b0;
        if (!stable_d[ChPill] || !rep_en) begin
            rep_state_d = RIdle;
            rep_cnt_d   = '0;
        end else begin
            unique case (rep_state_q)
                RIdle: begin
                    if (rise[ChPill]) begin
                        rep_state_d = RDelay;
                        rep_cnt_d   = '0;
                    end
                end
                RDelay: begin
                    if (rep_cnt_q == DelayLast) begin
                        rep_fire    = 1'b1;
                        rep_cnt_d   = '0;
                        rep_state_d = RRepeat;
                    end else begin
                        rep_cnt_d = rep_cnt_q + RepW'(1);
                    end
                end
                RRepeat: begin
                    if (rep_cnt_q == RateLast) begin
                        rep_fire  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + RepW'(1);
                    end
                end
                default: begin
                    rep_state_d = RIdle;
                    rep_cnt_d   = '0;
                end
            endcase
        end
        pill_d = rise[ChPill] | rep_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_state_q <= RIdle;
            rep_cnt_q   <= '0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            pill_q      <= 1'b0;
        end else begin
            rep_state_q <= rep_state_d;
            rep_cnt_q   <= rep_cnt_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            pill_q      <= pill_d;
        end
    end

    assign start      = start_q;
    assign stop       = stop_q;
    assign pill_pulse = pill_q;
    assign bottle_ok  = stable_q[ChBottle];
    assign key_held   = stable_q[2:0];

endmodule
